// File: rtl/stream_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_sel_pkg
// Description : Shared types and constants for the stream selector: FSM state
//               enum, TCON packing widths and the packing zero-fill constant.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_sel_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } sel_state_t;

    // TCON word width and the per-component width taken from each colour
    localparam int C_TCON_W  = 16;
    localparam int C_TCON_CW = 8;

    // Zero fill inserted by the TCON packing
    localparam logic [1:0] C_PACK_ZFILL = 2'b00;

endpackage
`default_nettype wire

// File: rtl/tcon_pack.sv
`default_nettype none
// ============================================================================
// Module      : tcon_pack
// Description : Combinational TCON packer. Takes the top 8 bits of each DW-bit
//               colour component and splits them over two 16-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
import stream_sel_pkg::*;

module tcon_pack #(
    parameter int DW = 8
) (
    input  logic [DW-1:0]       iR,
    input  logic [DW-1:0]       iG,
    input  logic [DW-1:0]       iB,
    output logic [C_TCON_W-1:0] oWr1_data,
    output logic [C_TCON_W-1:0] oWr2_data
);

    logic [C_TCON_CW-1:0] w_r8;
    logic [C_TCON_CW-1:0] w_g8;
    logic [C_TCON_CW-1:0] w_b8;

    assign w_r8 = iR[DW-1 -: C_TCON_CW];
    assign w_g8 = iG[DW-1 -: C_TCON_CW];
    assign w_b8 = iB[DW-1 -: C_TCON_CW];

    // Green is split: upper five bits ride with red, lower three with blue
    assign oWr1_data = {1'b0, w_g8[7:3], w_r8, C_PACK_ZFILL};
    assign oWr2_data = {1'b0, w_g8[2:0], C_PACK_ZFILL, w_b8, C_PACK_ZFILL};

endmodule
`default_nettype wire

// File: rtl/stream_selector.sv
`default_nettype none
// ============================================================================
// Module      : stream_selector
// Description : Selects one of N_CH RGB pixel streams for a TCON. Channel
//               switches are deferred to the next frame start and followed by
//               BLANK_CYC cycles of suppressed output. Two-cycle latency.
//               Optional: define STREAM_SELECTOR_STATS_EN to add oFrame_pix,
//               the valid-pixel count of the previous frame.
// Revision    : 1.0 - initial release
// ============================================================================
import stream_sel_pkg::*;

module stream_selector #(
    parameter int              N_CH      = 4,
    parameter int              DW        = 8,
    parameter logic [N_CH-1:0] MONO_MASK = 4'b1110,
    parameter int              BLANK_CYC = 16
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic [$clog2(N_CH+1)-1:0]   iSelect,
    input  logic                        iFrame_start,
    input  logic [N_CH-1:0]             iValid,
    input  logic [N_CH*3*DW-1:0]        iData,
    output logic [DW-1:0]               oR,
    output logic [DW-1:0]               oG,
    output logic [DW-1:0]               oB,
    output logic                        oWr1_valid,
    output logic                        oWr2_valid,
    output logic [15:0]                 oWr1_data,
    output logic [15:0]                 oWr2_data,
    output logic [$clog2(N_CH+1)-1:0]   oActive,
    output logic                        oSwitching
`ifdef STREAM_SELECTOR_STATS_EN
    ,
    output logic [23:0]                 oFrame_pix
`endif
);

    localparam int          SW      = $clog2(N_CH+1);
    localparam logic [7:0]  C_BLANK = 8'(BLANK_CYC);

    // Stage 1 registers
    logic [SW-1:0]        sel_q;
    logic                 fs_q;
    logic [N_CH-1:0]      valid_q;
    logic [N_CH*3*DW-1:0] data_q;

    // Control state
    sel_state_t  state_q, state_d;
    logic [SW-1:0] act_q, act_d;
    logic [SW-1:0] pend_q, pend_d;
    logic [7:0]    cnt_q, cnt_d;

    // Stage 2 registers
    logic [DW-1:0] r_q, g_q, b_q;
    logic          vld_q;
    logic [15:0]   wr1_q, wr2_q;
    logic [SW-1:0] act_out_q;
    logic          sw_q;

    // Selected, gated pixel feeding stage 2
    logic [DW-1:0] w_pix_r, w_pix_g, w_pix_b;
    logic          w_pix_v;
    logic          w_live;
    logic [15:0]   w_wr1, w_wr2;

    // Stage 1: capture all inputs every cycle
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sel_q   <= '0;
            fs_q    <= 1'b0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            sel_q   <= iSelect;
            fs_q    <= iFrame_start;
            valid_q <= iValid;
            data_q  <= iData;
        end
    end

    // Switch control: detect select change, wait for frame start, then blank
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                // A frame start in the same cycle does not complete the switch
                if (sel_q != act_q) begin
                    pend_d  = sel_q;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                pend_d = sel_q;
                if (sel_q == act_q) begin
                    state_d = ST_RUN;
                end else if (fs_q) begin
                    act_d   = pend_q;
                    cnt_d   = C_BLANK;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Control state registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_RUN;
            act_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pick the active channel, apply mono expansion and valid gating
    always_comb begin
        w_live  = (state_q != ST_BLANK);
        w_pix_r = '0;
        w_pix_g = '0;
        w_pix_b = '0;
        w_pix_v = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_live && (act_q == SW'(k + 1))) begin
                w_pix_v = valid_q[k];
                w_pix_r = data_q[k*3*DW + 2*DW +: DW];
                w_pix_g = data_q[k*3*DW + DW   +: DW];
                w_pix_b = data_q[k*3*DW        +: DW];
                if (MONO_MASK[k]) begin
                    w_pix_g = data_q[k*3*DW + 2*DW +: DW];
                    w_pix_b = data_q[k*3*DW + 2*DW +: DW];
                end
            end
        end
        if (!w_pix_v) begin
            w_pix_r = '0;
            w_pix_g = '0;
            w_pix_b = '0;
        end
    end

    tcon_pack #(
        .DW (DW)
    ) u_tcon_pack (
        .iR        (w_pix_r),
        .iG        (w_pix_g),
        .iB        (w_pix_b),
        .oWr1_data (w_wr1),
        .oWr2_data (w_wr2)
    );

    // Stage 2: register every output
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            vld_q     <= 1'b0;
            wr1_q     <= '0;
            wr2_q     <= '0;
            act_out_q <= '0;
            sw_q      <= 1'b0;
        end else begin
            r_q       <= w_pix_r;
            g_q       <= w_pix_g;
            b_q       <= w_pix_b;
            vld_q     <= w_pix_v;
            wr1_q     <= w_wr1;
            wr2_q     <= w_wr2;
            act_out_q <= act_q;
            sw_q      <= (state_q != ST_RUN);
        end
    end

    assign oR         = r_q;
    assign oG         = g_q;
    assign oB         = b_q;
    assign oWr1_valid = vld_q;
    assign oWr2_valid = vld_q;
    assign oWr1_data  = wr1_q;
    assign oWr2_data  = wr2_q;
    assign oActive    = act_out_q;
    assign oSwitching = sw_q;

`ifdef STREAM_SELECTOR_STATS_EN
    logic        fs2_q;
    logic [23:0] pix_cnt_q, pix_cnt_d;
    logic [23:0] frame_pix_q, frame_pix_d;

    // Frame pixel counter aligned with stage 2; the pixel coinciding with
    // the frame start is the first pixel of the new frame
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        frame_pix_d = frame_pix_q;
        if (fs2_q) begin
            frame_pix_d = pix_cnt_q;
            pix_cnt_d   = {23'd0, vld_q};
        end else if (vld_q && (pix_cnt_q != 24'hFF_FFFF)) begin
            pix_cnt_d = pix_cnt_q + 24'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fs2_q       <= 1'b0;
            pix_cnt_q   <= '0;
            frame_pix_q <= '0;
        end else begin
            fs2_q       <= fs_q;
            pix_cnt_q   <= pix_cnt_d;
            frame_pix_q <= frame_pix_d;
        end
    end

    assign oFrame_pix = frame_pix_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_selector
// Description : Self-checking bench for stream_selector with a behavioural
//               reference model (pipeline history + switch bookkeeping).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_selector;

    localparam int              N_CH      = 4;
    localparam int              DW        = 8;
    localparam int              BLANK_CYC = 16;
    localparam int              SW        = $clog2(N_CH+1);
    localparam int              XW        = N_CH*3*DW;
    localparam logic [N_CH-1:0] MONO      = 4'b1110;

    logic            iClk = 1'b0;
    logic            iRst = 1'b1;
    logic [SW-1:0]   iSelect = '0;
    logic            iFrame_start = 1'b0;
    logic [N_CH-1:0] iValid = '0;
    logic [XW-1:0]   iData = '0;
    logic [DW-1:0]   oR, oG, oB;
    logic            oWr1_valid, oWr2_valid;
    logic [15:0]     oWr1_data, oWr2_data;
    logic [SW-1:0]   oActive;
    logic            oSwitching;
`ifdef STREAM_SELECTOR_STATS_EN
    logic [23:0]     oFrame_pix;
`endif

    stream_selector #(
        .N_CH      (N_CH),
        .DW        (DW),
        .MONO_MASK (MONO),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iSelect      (iSelect),
        .iFrame_start (iFrame_start),
        .iValid       (iValid),
        .iData        (iData),
        .oR           (oR),
        .oG           (oG),
        .oB           (oB),
        .oWr1_valid   (oWr1_valid),
        .oWr2_valid   (oWr2_valid),
        .oWr1_data    (oWr1_data),
        .oWr2_data    (oWr2_data),
        .oActive      (oActive),
        .oSwitching   (oSwitching)
`ifdef STREAM_SELECTOR_STATS_EN
        ,
        .oFrame_pix   (oFrame_pix)
`endif
    );

    always #5 iClk = ~iClk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: inputs as seen one clock ago, switch bookkeeping,
    // and the outputs expected after the current edge
    logic [SW-1:0]   m_sel;
    logic            m_fs;
    logic [N_CH-1:0] m_valid;
    logic [XW-1:0]   m_data;
    int  act, pend, blank_left;
    bit  waiting;
    logic [DW-1:0] e_r, e_g, e_b;
    bit  e_v, e_sw, e_fs2;
    logic [15:0] e_w1, e_w2;
    int  e_act, cnt, e_fp;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_advance();
        logic [XW-1:0] sh;
        int r, g, b, ch;
        bit v;
        if (iRst) begin
            m_sel = '0; m_fs = 1'b0; m_valid = '0; m_data = '0;
            act = 0; pend = 0; blank_left = 0; waiting = 0;
            e_r = '0; e_g = '0; e_b = '0; e_v = 0; e_w1 = '0; e_w2 = '0;
            e_act = 0; e_sw = 0; e_fs2 = 0; cnt = 0; e_fp = 0;
        end else begin
            // frame statistics use the output valid of the previous cycle
            if (e_fs2) begin
                e_fp = cnt;
                cnt  = e_v ? 1 : 0;
            end else if (e_v && cnt < 24'hFF_FFFF) begin
                cnt++;
            end
            e_fs2 = m_fs;
            v = 0; r = 0; g = 0; b = 0;
            if (blank_left == 0 && act >= 1 && act <= N_CH) v = m_valid[act-1];
            if (v) begin
                ch = act - 1;
                sh = m_data >> (ch*3*DW);
                b  = int'(sh[DW-1:0]);
                sh = sh >> DW;
                g  = int'(sh[DW-1:0]);
                sh = sh >> DW;
                r  = int'(sh[DW-1:0]);
                if (MONO[ch]) begin
                    g = r;
                    b = r;
                end
            end
            e_r = DW'(r); e_g = DW'(g); e_b = DW'(b); e_v = v;
            e_w1 = 16'(((g >> (DW-8)) / 8) * 1024 + (r >> (DW-8)) * 4);
            e_w2 = 16'(((g >> (DW-8)) % 8) * 4096 + (b >> (DW-8)) * 4);
            e_act = act;
            e_sw  = waiting || (blank_left > 0);
            if (blank_left > 0) begin
                blank_left--;
            end else if (waiting) begin
                if (int'(m_sel) == act) begin
                    waiting = 0;
                end else if (m_fs) begin
                    act        = pend;
                    blank_left = BLANK_CYC;
                    waiting    = 0;
                end
                pend = int'(m_sel);
            end else if (int'(m_sel) != act) begin
                pend    = int'(m_sel);
                waiting = 1;
            end
            m_sel = iSelect; m_fs = iFrame_start; m_valid = iValid; m_data = iData;
        end
    endtask

    task automatic check_all();
        chk("r", 32'(oR), 32'(e_r));
        chk("g", 32'(oG), 32'(e_g));
        chk("b", 32'(oB), 32'(e_b));
        chk("wr1_valid", 32'(oWr1_valid), 32'(e_v));
        chk("wr2_valid", 32'(oWr2_valid), 32'(e_v));
        chk("wr1_data", 32'(oWr1_data), 32'(e_w1));
        chk("wr2_data", 32'(oWr2_data), 32'(e_w2));
        chk("active", 32'(oActive), 32'(e_act));
        chk("switching", 32'(oSwitching), 32'(e_sw));
`ifdef STREAM_SELECTOR_STATS_EN
        chk("frame_pix", 32'(oFrame_pix), 32'(e_fp));
`endif
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
        model_advance();
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_data();
        iData = XW'({$urandom, $urandom, $urandom});
    endtask

    initial begin
        // Reset held for a few cycles
        iRst = 1'b1;
        iValid = '1;
        rand_data();
        steps(3);
        chk("rst_active", 32'(oActive), 32'd0);
        iRst = 1'b0;

        // Output off with select 0 even though every channel is valid
        for (int i = 0; i < 100; i++) begin
            rand_data();
            step();
            chk("off_valid", 32'(oWr1_valid), 32'd0);
            chk("off_data", 32'(oWr1_data), 32'd0);
            chk("off_active", 32'(oActive), 32'd0);
        end

        // Switch to channel 0, timed from the frame start
        iSelect = SW'(1);
        steps(5);
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("sw_hold", 32'(oSwitching), 32'd1);
        end
        step();
        chk("sw_release", 32'(oSwitching), 32'd0);
        iValid = 4'b0001;
        iData = '0;
        iData[23:0] = 24'h123456;
        steps(2);
        chk("ch0_wr1", 32'(oWr1_data), 32'h1848);
        chk("ch0_wr2", 32'(oWr2_data), 32'h4158);
        chk("ch0_active", 32'(oActive), 32'd1);

        // Select wanders 2 -> 3 -> 1 without a frame start: no blanking
        iValid = '1;
        iSelect = SW'(2);
        for (int i = 0; i < 2; i++) begin step(); chk("nb_valid", 32'(oWr1_valid), 32'd1); end
        iSelect = SW'(3);
        for (int i = 0; i < 2; i++) begin step(); chk("nb_valid", 32'(oWr1_valid), 32'd1); end
        iSelect = SW'(1);
        for (int i = 0; i < 4; i++) begin step(); chk("nb_valid", 32'(oWr1_valid), 32'd1); end
        chk("nb_active", 32'(oActive), 32'd1);
        chk("nb_switching", 32'(oSwitching), 32'd0);

        // Switch to mono channel 1
        iData = '0;
        iData[47:24] = 24'hA01234;
        iSelect = SW'(2);
        steps(3);
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        steps(22);
        chk("mono_r", 32'(oR), 32'hA0);
        chk("mono_g", 32'(oG), 32'hA0);
        chk("mono_b", 32'(oB), 32'hA0);
        chk("mono_wr1", 32'(oWr1_data), 32'h5280);
        chk("mono_wr2", 32'(oWr2_data), 32'h0280);

        // Reset in the middle of blanking abandons the switch
        iSelect = SW'(3);
        steps(3);
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        begin
            int guard;
            guard = 0;
            while (blank_left != 5 && guard < 40) begin
                step();
                guard++;
            end
            chk("blank_reach", 32'(guard < 40), 32'd1);
        end
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rand_data();
            step();
            chk("abandon_active", 32'(oActive), 32'd0);
            chk("abandon_valid", 32'(oWr1_valid), 32'd0);
        end

        // Frame pixel statistics: 640 valid pixels on channel 0
        iSelect = SW'(1);
        iValid = '0;
        steps(3);
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        steps(22);
        iFrame_start = 1'b1;
        iValid = 4'b0001;
        step();
        iFrame_start = 1'b0;
        steps(639);
        iValid = '0;
        steps(10);
        iFrame_start = 1'b1;
        step();
        iFrame_start = 1'b0;
        steps(2);
`ifdef STREAM_SELECTOR_STATS_EN
        chk("frame_640", 32'(oFrame_pix), 32'd640);
`endif

        // Randomized traffic against the reference model
        for (int t = 0; t < 3000; t++) begin
            iValid = N_CH'($urandom);
            rand_data();
            iFrame_start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) iSelect = SW'($urandom_range(0, (1 << SW) - 1));
            iRst = ($urandom_range(0, 599) == 0);
            step();
        end
        iRst = 1'b0;
        iFrame_start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_selector.md
STREAM_SELECTOR -- requirements
Module: stream_selector

Interface
REQ-001 The block SHALL have parameter N_CH, default 4; it is the number of input pixel channels (2..8).
REQ-002 The block SHALL have parameter DW, default 8; it is the bits per colour component (8..12).
REQ-003 The block SHALL have parameter MONO_MASK, default 4'b1110; bit k=1 means channel k carries mono data in component 0.
REQ-004 The block SHALL have parameter BLANK_CYC, default 16; it is the number of cycles the output is suppressed after a switch (1..255).
REQ-005 The block SHALL have port iClk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port iSelect, input, SW=$clog2(N_CH+1) bits: 0 means output off, k in 1..N_CH means channel k-1.
REQ-008 The block SHALL have port iFrame_start, input, 1 bit: single-cycle start-of-frame pulse, common to all channels.
REQ-009 The block SHALL have port iValid, input, N_CH bits: per-channel pixel valid.
REQ-010 The block SHALL have port iData, input, N_CH*3*DW bits: per channel {R,G,B}, with channel 0 in the LSBs.
REQ-011 The block SHALL have ports oR, oG and oB, outputs, DW bits each: the selected pixel.
REQ-012 The block SHALL have ports oWr1_valid and oWr2_valid, outputs, 1 bit each: pixel-valid strobes to the TCON.
REQ-013 The block SHALL have ports oWr1_data and oWr2_data, outputs, 16 bits each: TCON-packed pixel.
REQ-014 The block SHALL have port oActive, output, SW bits: the select value currently in effect.
REQ-015 The block SHALL have port oSwitching, output, 1 bit: high while state is PEND or BLANK.

Function
REQ-016 Stage 1 SHALL register iSelect, iFrame_start, iValid and iData every cycle; stage 2 SHALL register all outputs, giving a 2-cycle latency from input to output.
REQ-017 The FSM SHALL have states RUN, PEND and BLANK, with an active select register act and a pending register pend.
- RUN: if the registered select differs from act, latch pend and go to PEND.
- PEND: pend tracks the registered select every cycle; if the registered select equals act, go to RUN; on a registered frame-start, set act<=pend, load the blank counter with BLANK_CYC and go to BLANK.
- BLANK: decrement the counter; at 0 go to RUN; frame-start and select changes are ignored until RUN is reached, and a pending difference is then re-detected.
REQ-018 Valid gating SHALL hold: in RUN and PEND the output carries channel act-1 with valid = iValid[act-1]; in BLANK, when act=0, or when act>N_CH, all valids are 0 and oR/oG/oB are 0.
REQ-019 Mono handling SHALL apply: when MONO_MASK[ch]=1, oR=oG=oB equal component R of that channel; otherwise the channel passes RGB through unchanged.
REQ-020 When the selected channel's valid is 0, oR/oG/oB SHALL be forced to 0.
REQ-021 Packing SHALL use the top 8 bits of each component (r8, g8, b8): oWr1_data = {0, g8[7:3], r8, 00} and oWr2_data = {0, g8[2:0], 00, b8, 00}.
REQ-022 oWr1_valid and oWr2_valid SHALL always be equal.
REQ-023 A select change and a frame-start arriving in the same registered cycle while in RUN SHALL go to PEND only; the switch then waits for the next frame-start.

Reset
REQ-024 While iRst is high at a clock edge, the block SHALL force: state=RUN, act=0, pend=0, counter=0, all stage-1 registers 0, and all outputs 0.
REQ-025 Reset asserted mid-PEND or mid-BLANK SHALL abandon the switch; after release, output stays off until a select change followed by a frame-start.

Configuration
REQ-026 With STREAM_SELECTOR_STATS_EN defined, the block SHALL add output oFrame_pix (24 bits), holding the count of output valid pixels during the previous frame.
- The count is latched and the counter cleared on each stage-2-aligned frame-start.
- The counter saturates at 2^24-1.
- Reset value is 0.
REQ-027 Without STREAM_SELECTOR_STATS_EN, the oFrame_pix port and its counter SHALL be absent.

Structure
REQ-028 A shared package stream_sel_pkg SHALL hold the FSM state enum (RUN, PEND, BLANK), the TCON packing widths, and a pack-function constant for the zero fill.
REQ-029 The block SHALL contain one sub-module, tcon_pack, which takes DW-bit R/G/B and produces oWr1_data/oWr2_data combinationally.

Verification
REQ-030 After reset, with iSelect=0 and all iValid=1, the bench SHALL see oWr1_valid=0, all data 0 and oActive=0 for 100 cycles.
REQ-031 With iSelect=1 held, then one frame-start, the bench SHALL see oSwitching=1 until 16 cycles after frame-start plus 2; ch0 pixel {0x12,0x34,0x56} then gives oWr1_data=0x1848 and oWr2_data=0x4158.
REQ-032 With act=1 and iSelect=2 (mono ch1, R=0xA0), frame-start, BLANK elapses; the bench SHALL see oR=oG=oB=0xA0 and oWr1_data=0x5280.
REQ-033 In PEND, iSelect 2->3->1 before any frame-start: the bench SHALL see a return to RUN with act=1 and no blanking.
REQ-034 With iRst asserted at BLANK counter=5: the bench SHALL see act=0, outputs 0, and no transition to RUN carrying the old pend.
REQ-035 With STATS_EN, 640 valid pixels between two frame-starts: the bench SHALL see oFrame_pix=640 after the second frame-start plus 2 cycles.
